// File: rtl/scanflop_drv.sv
// Four-phase initiator for the dual-rail scan flop: one command at a time, encoded onto the
// data/select rails, full return-to-zero handshake, decoded response. Optional REQ timeout: SCANFLOP_DRV_TIMEOUT_EN.
module scanflop_drv #(
  parameter int SETUP_CYC   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_sel,
  input  logic cmd_hold,
  input  logic cmd_d,
  output logic in1_0,
  output logic in1_1,
  output logic in2_0,
  output logic in2_1,
  output logic sel0,
  output logic sel1,
  output logic req,
  input  logic q0,
  input  logic q1,
  input  logic ack,
  output logic rsp_valid,
  output logic rsp_q,
  output logic rsp_err,
  output logic rsp_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_REQ,
    ST_CAPTURE,
    ST_RELEASE,
    ST_WAIT0
  } state_t;

  localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
  localparam int TO_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : TO_RAW;

  state_t state_q, state_d;
  logic [3:0] setup_cnt_q, setup_cnt_d;
  logic sel0_q, sel0_d, sel1_q, sel1_d;
  logic in1_0_q, in1_0_d, in1_1_q, in1_1_d;
  logic in2_0_q, in2_0_d, in2_1_q, in2_1_d;
  logic req_q, req_d;
  logic cmd_ready_q, cmd_ready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_q_q, rsp_q_d;
  logic rsp_err_q, rsp_err_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0] q0_sync_q, q0_sync_d;
  logic [SYNC_STAGES-1:0] q1_sync_q, q1_sync_d;
  logic ack_s, q0_s, q1_s;

`ifdef SCANFLOP_DRV_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic rsp_timeout_q, rsp_timeout_d;
`else
  logic [TO_W-1:0] unused_to_limit;
  assign unused_to_limit = TO_W'(TIMEOUT_CYC);
`endif

  always_comb begin
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], ack};
    q0_sync_d  = {q0_sync_q[SYNC_STAGES-2:0], q0};
    q1_sync_d  = {q1_sync_q[SYNC_STAGES-2:0], q1};
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign q0_s  = q0_sync_q[SYNC_STAGES-1];
  assign q1_s  = q1_sync_q[SYNC_STAGES-1];

  // Rails are registered straight from the accepted command so they stay glitch-free for the flop.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    sel0_d      = sel0_q;
    sel1_d      = sel1_q;
    in1_0_d     = in1_0_q;
    in1_1_d     = in1_1_q;
    in2_0_d     = in2_0_q;
    in2_1_d     = in2_1_q;
    req_d       = req_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
`ifdef SCANFLOP_DRV_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          state_d     = ST_SETUP;
          setup_cnt_d = SETUP_LOAD;
          sel0_d      = ~cmd_sel;
          sel1_d      = cmd_sel;
          in1_1_d     = ~cmd_sel & cmd_d & ~cmd_hold;
          in1_0_d     = ~cmd_sel & ~cmd_d & ~cmd_hold;
          in2_1_d     = cmd_sel & cmd_d & ~cmd_hold;
          in2_0_d     = cmd_sel & ~cmd_d & ~cmd_hold;
        end
      end
      ST_SETUP: begin
        if (setup_cnt_q == 4'd0) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
`ifdef SCANFLOP_DRV_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          setup_cnt_d = setup_cnt_q - 4'd1;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_d     = ST_CAPTURE;
          rsp_valid_d = 1'b1;
          rsp_q_d     = q1_s;
          rsp_err_d   = (q0_s == q1_s);
`ifdef SCANFLOP_DRV_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = ST_CAPTURE;
          rsp_valid_d   = 1'b1;
          rsp_q_d       = 1'b0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      ST_CAPTURE: begin
        state_d = ST_RELEASE;
        req_d   = 1'b0;
        sel0_d  = 1'b0;
        sel1_d  = 1'b0;
        in1_0_d = 1'b0;
        in1_1_d = 1'b0;
        in2_0_d = 1'b0;
        in2_1_d = 1'b0;
      end
      ST_RELEASE: begin
        state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        // The flop must be fully back to null before the next command can start.
        if (!ack_s && !q0_s && !q1_s) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_d       = 1'b0;
        cmd_ready_d = 1'b0;
        sel0_d      = 1'b0;
        sel1_d      = 1'b0;
        in1_0_d     = 1'b0;
        in1_1_d     = 1'b0;
        in2_0_d     = 1'b0;
        in2_1_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= 4'd0;
      sel0_q      <= 1'b0;
      sel1_q      <= 1'b0;
      in1_0_q     <= 1'b0;
      in1_1_q     <= 1'b0;
      in2_0_q     <= 1'b0;
      in2_1_q     <= 1'b0;
      req_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      ack_sync_q  <= '0;
      q0_sync_q   <= '0;
      q1_sync_q   <= '0;
`ifdef SCANFLOP_DRV_TIMEOUT_EN
      to_cnt_q      <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      sel0_q      <= sel0_d;
      sel1_q      <= sel1_d;
      in1_0_q     <= in1_0_d;
      in1_1_q     <= in1_1_d;
      in2_0_q     <= in2_0_d;
      in2_1_q     <= in2_1_d;
      req_q       <= req_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      rsp_err_q   <= rsp_err_d;
      ack_sync_q  <= ack_sync_d;
      q0_sync_q   <= q0_sync_d;
      q1_sync_q   <= q1_sync_d;
`ifdef SCANFLOP_DRV_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign sel0      = sel0_q;
  assign sel1      = sel1_q;
  assign in1_0     = in1_0_q;
  assign in1_1     = in1_1_q;
  assign in2_0     = in2_0_q;
  assign in2_1     = in2_1_q;
  assign req       = req_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;
`ifdef SCANFLOP_DRV_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule
